// File: rtl/fab_uart_rx.sv
// ---------------------------------------------------------------------------
// fab_uart_rx
//   Fabric-side UART receiver for the serial stream leaving MMUART_0_TXD.
//   A 16x oversampling front end feeds a first-word-fallthrough receive FIFO.
//   Default frame format is 8N1. Defining FAB_UART_RX_PARITY_EN switches the
//   frame to 8E1 and adds the PARITY_ERR port.
//
// Parameters
//   BAUD_DIV : CLK_BASE cycles per oversample tick (1..65535)
//   FIFO_AW  : FIFO address width, depth = 2**FIFO_AW bytes
//
// Ports
//   CLK_BASE    in   fabric clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   RXD         in   serial input, asynchronous, idles high
//   RX_DATA     out  byte at FIFO head (0 while FIFO empty)
//   RX_VALID    out  FIFO non-empty
//   RX_READY    in   consumer pops RX_DATA when RX_VALID & RX_READY
//   FIFO_COUNT  out  FIFO occupancy
//   FRAMING_ERR out  one-cycle pulse, stop bit sampled low
//   PARITY_ERR  out  one-cycle pulse, even-parity mismatch (macro only)
//   OVERFLOW    out  one-cycle pulse, byte dropped because FIFO full
// ---------------------------------------------------------------------------
module fab_uart_rx #(
   parameter int BAUD_DIV = 27,
   parameter int FIFO_AW  = 4
) (
   input  logic               CLK_BASE,
   input  logic               RESET_N,
   input  logic               RXD,
   output logic [7:0]         RX_DATA,
   output logic               RX_VALID,
   input  logic               RX_READY,
   output logic [FIFO_AW:0]   FIFO_COUNT,
   output logic               FRAMING_ERR,
`ifdef FAB_UART_RX_PARITY_EN
   output logic               PARITY_ERR,
`endif
   output logic               OVERFLOW
);

   localparam int          DATA_W    = 8;
   localparam int          DEPTH     = 2 ** FIFO_AW;
   localparam logic [15:0] TICK_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef FAB_UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t              state_q, state_d;
   logic                rxd_m, rxd_s, rxd_d;
   logic [15:0]         tick_cnt;
   logic                tick;
   logic [3:0]          os_cnt;
   logic [2:0]          bit_cnt;
   logic [DATA_W-1:0]   shreg;
   logic                os_clr, bit_clr, shift_en, push, ferr_d;
   logic                mid_tick, end_tick;
`ifdef FAB_UART_RX_PARITY_EN
   logic                par_smp, par_bad_q, perr_d;
`endif

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [FIFO_AW:0]    wr_ptr, rd_ptr;
   logic                full, pop, wr_en;

   // ---- input synchronizer and falling-edge history ----
   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_d <= 1'b1;
      end else begin
         rxd_m <= RXD;
         rxd_s <= rxd_m;
         rxd_d <= rxd_s;
      end
   end

   // ---- free-running oversample tick ----
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N) tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 16'd1;
   end

   // ---- frame FSM ----
   assign mid_tick = tick && (os_cnt == 4'd7);
   assign end_tick = tick && (os_cnt == 4'd15);

   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      os_clr   = 1'b0;
      bit_clr  = 1'b0;
      shift_en = 1'b0;
      push     = 1'b0;
      ferr_d   = 1'b0;
`ifdef FAB_UART_RX_PARITY_EN
      par_smp  = 1'b0;
      perr_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (rxd_d && !rxd_s) begin
               os_clr  = 1'b1;
               bit_clr = 1'b1;
               state_d = START;
            end
         end
         START: begin
            // a start bit that is high again at mid-bit is a glitch
            if (mid_tick) begin
               if (!rxd_s) begin
                  os_clr  = 1'b1;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (end_tick) begin
               shift_en = 1'b1;
               os_clr   = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef FAB_UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef FAB_UART_RX_PARITY_EN
         PARITY: begin
            if (end_tick) begin
               par_smp = 1'b1;
               os_clr  = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // IDLE waits for a fresh falling edge, so a break reports once
            if (end_tick) begin
               os_clr  = 1'b1;
               state_d = IDLE;
               if (rxd_s) push   = 1'b1;
               else       ferr_d = 1'b1;
`ifdef FAB_UART_RX_PARITY_EN
               perr_d = par_bad_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- oversample / bit counters and shift register ----
   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N) begin
         os_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         if (os_clr)    os_cnt <= '0;
         else if (tick) os_cnt <= os_cnt + 4'd1;
         if (bit_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shreg <= {rxd_s, shreg[DATA_W-1:1]};
      end
   end

`ifdef FAB_UART_RX_PARITY_EN
   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N)     par_bad_q <= 1'b0;
      else if (par_smp) par_bad_q <= rxd_s ^ (^shreg);
   end
`endif

   // ---- receive FIFO ----
   assign FIFO_COUNT = wr_ptr - rd_ptr;
   assign full       = FIFO_COUNT[FIFO_AW];
   assign RX_VALID   = (FIFO_COUNT != '0);
   assign pop        = RX_VALID & RX_READY;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr_en      = push & (~full | pop);
   assign RX_DATA    = RX_VALID ? mem[rd_ptr[FIFO_AW-1:0]] : '0;

   always_ff @(posedge CLK_BASE) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
   end

   always_ff @(posedge CLK_BASE or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         FRAMING_ERR <= 1'b0;
         OVERFLOW    <= 1'b0;
`ifdef FAB_UART_RX_PARITY_EN
         PARITY_ERR  <= 1'b0;
`endif
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         FRAMING_ERR <= ferr_d;
         OVERFLOW    <= push & full & ~pop;
`ifdef FAB_UART_RX_PARITY_EN
         PARITY_ERR  <= perr_d;
`endif
      end
   end

endmodule

// File: tb/tb_fab_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_fab_uart_rx
//   Directed bench for fab_uart_rx with BAUD_DIV=2 (32 clocks per bit) and
//   FIFO_AW=4. Table-driven frames plus hand-written multi-cycle sequences:
//   glitch, break, overflow, push/pop on a full FIFO, reset mid-frame and,
//   with FAB_UART_RX_PARITY_EN, a bad parity bit.
// ---------------------------------------------------------------------------
module tb_fab_uart_rx;

   localparam int FIFO_AW  = 4;
   localparam int BIT_CLKS = 32;
`ifdef FAB_UART_RX_PARITY_EN
   localparam int L_MIN = 18 + BIT_CLKS * 10;
`else
   localparam int L_MIN = 18 + BIT_CLKS * 9;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             rxd = 1'b1;
   logic             rdy = 1'b0;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [FIFO_AW:0] fifo_count;
   logic             framing_err;
   logic             overflow;
`ifdef FAB_UART_RX_PARITY_EN
   logic             parity_err;
   logic             par_flip = 1'b0;
   int               perr_cnt = 0;
`endif

   fab_uart_rx #(.BAUD_DIV(2), .FIFO_AW(FIFO_AW)) dut (
      .CLK_BASE    (clk),
      .RESET_N     (rst_n),
      .RXD         (rxd),
      .RX_DATA     (rx_data),
      .RX_VALID    (rx_valid),
      .RX_READY    (rdy),
      .FIFO_COUNT  (fifo_count),
      .FRAMING_ERR (framing_err),
`ifdef FAB_UART_RX_PARITY_EN
      .PARITY_ERR  (parity_err),
`endif
      .OVERFLOW    (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   int ferr_cnt = 0, ovf_cnt = 0;
   int t_start = 0, cnt_mid_stop = 0;

   always @(negedge clk) begin
      if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
      if (overflow === 1'b1)    ovf_cnt  = ovf_cnt + 1;
`ifdef FAB_UART_RX_PARITY_EN
      if (parity_err === 1'b1)  perr_cnt = perr_cnt + 1;
`endif
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: actual=still running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk); #1 rxd = b;
      repeat (BIT_CLKS - 1) @(posedge clk);
   endtask

   // start bit, 8 data bits LSB first, optional parity, stop bit;
   // occupancy is sampled just after the stop bit starts
   task automatic send_frame(input logic [7:0] d, input logic stop);
      @(posedge clk); #1 rxd = 1'b0;
      t_start = cyc;
      repeat (BIT_CLKS - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef FAB_UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      @(posedge clk); #1 rxd = stop;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cnt_mid_stop = int'(fifo_count);
      repeat (BIT_CLKS - 4) @(posedge clk);
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk({nm, " valid"}, rx_valid, 1'b1);
      chk({nm, " data"}, rx_data, exp);
      rdy = 1'b1;
      @(posedge clk); #1 rdy = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_cnt;
      logic [7:0] exp_head;
      int         exp_ferr;
   } vec_t;

   vec_t tbl[5];
   int   f0, o0, prev_cnt, lat, w;

   initial begin
      tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      tbl[1] = '{8'h3C, 1'b0, 1, 8'hA5, 1};
      tbl[2] = '{8'hFF, 1'b1, 2, 8'hA5, 0};
      tbl[3] = '{8'h00, 1'b1, 3, 8'hA5, 0};
      tbl[4] = '{8'h81, 1'b1, 4, 8'hA5, 0};
      lat = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset valid", rx_valid, 1'b0);
      chk("reset count", fifo_count, 0);
      chk("reset data", rx_data, 8'h00);
      chk("reset ferr", framing_err, 1'b0);
      chk("reset ovf", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);

      // table-driven frames, RX_READY held low
      prev_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         f0 = ferr_cnt;
         o0 = ovf_cnt;
         send_frame(tbl[i].data, tbl[i].stop);
         chk($sformatf("vec%0d count before stop", i), cnt_mid_stop, prev_cnt);
         send_bit(1'b1);
         @(negedge clk);
         chk($sformatf("vec%0d count", i), fifo_count, tbl[i].exp_cnt);
         chk($sformatf("vec%0d valid", i), rx_valid, tbl[i].exp_cnt != 0);
         chk($sformatf("vec%0d head", i), rx_data, tbl[i].exp_head);
         chk($sformatf("vec%0d ferr pulses", i), ferr_cnt - f0, tbl[i].exp_ferr);
         chk($sformatf("vec%0d ovf pulses", i), ovf_cnt - o0, 0);
         prev_cnt = tbl[i].exp_cnt;
      end
      pop_chk("drain0", 8'hA5);
      pop_chk("drain1", 8'hFF);
      pop_chk("drain2", 8'h00);
      pop_chk("drain3", 8'h81);
      @(negedge clk);
      chk("drained count", fifo_count, 0);
      chk("drained valid", rx_valid, 1'b0);

      // 8-clock glitch on idle line
      f0 = ferr_cnt;
      @(posedge clk); #1 rxd = 1'b0;
      repeat (8) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (11 * BIT_CLKS) @(posedge clk);
      @(negedge clk);
      chk("glitch count", fifo_count, 0);
      chk("glitch ferr", ferr_cnt - f0, 0);
      send_frame(8'h81, 1'b1);
      send_bit(1'b1);
      @(negedge clk);
      chk("after glitch count", fifo_count, 1);
      pop_chk("after glitch", 8'h81);

      // bad stop bit followed by a held-low break
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      repeat (5 * BIT_CLKS) @(posedge clk);
      @(negedge clk);
      chk("break count", fifo_count, 0);
      chk("break ferr", ferr_cnt - f0, 1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(8'h81, 1'b1);
      send_bit(1'b1);
      @(negedge clk);
      chk("after break count", fifo_count, 1);
      chk("after break ferr", ferr_cnt - f0, 1);
      pop_chk("after break", 8'h81);

      // 17 bytes into a 16-deep FIFO
      o0 = ovf_cnt;
      for (int k = 0; k < 17; k++) begin
         send_frame(8'(k), 1'b1);
         send_bit(1'b1);
         if (k == 15) begin
            @(negedge clk);
            chk("fill16 count", fifo_count, 16);
            chk("fill16 ovf", ovf_cnt - o0, 0);
         end
      end
      @(negedge clk);
      chk("overflow count", fifo_count, 16);
      chk("overflow pulses", ovf_cnt - o0, 1);
      for (int k = 0; k < 16; k++) pop_chk($sformatf("ovf drain%0d", k), 8'(k));
      @(negedge clk);
      chk("ovf drained count", fifo_count, 0);

      // refill, timing the push of the 16th byte
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            fork
               send_frame(8'h20 + 8'(k), 1'b1);
               begin
                  @(posedge clk); #2;
                  w = 0;
                  while (fifo_count != 16 && w < 1000) begin
                     @(negedge clk);
                     w++;
                  end
                  lat = cyc - t_start;
               end
            join
         end else begin
            send_frame(8'h20 + 8'(k), 1'b1);
         end
         send_bit(1'b1);
      end
      chk("stop-sample latency in window", (lat >= L_MIN) && (lat <= L_MIN + 1), 1'b1);

      // pop exactly on the push edge of the next byte while full
      o0 = ovf_cnt;
      fork
         send_frame(8'h30, 1'b1);
         begin
            @(posedge clk); #2;
            w = 0;
            while (cyc != t_start + lat - 1 && w < 1000) begin
               @(negedge clk);
               w++;
            end
            rdy = 1'b1;
            @(posedge clk); #1 rdy = 1'b0;
         end
      join
      send_bit(1'b1);
      @(negedge clk);
      chk("full push+pop ovf", ovf_cnt - o0, 0);
      chk("full push+pop count", fifo_count, 16);
      for (int k = 1; k <= 16; k++) pop_chk($sformatf("pp drain%0d", k), 8'h20 + 8'(k));
      @(negedge clk);
      chk("pp drained count", fifo_count, 0);

      // reset mid-frame with three bytes queued
      send_frame(8'h11, 1'b1); send_bit(1'b1);
      send_frame(8'h22, 1'b1); send_bit(1'b1);
      send_frame(8'h33, 1'b1); send_bit(1'b1);
      @(negedge clk);
      chk("queued3 count", fifo_count, 3);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      rxd   = 1'b1;
      @(negedge clk);
      chk("midreset valid", rx_valid, 1'b0);
      chk("midreset count", fifo_count, 0);
      chk("midreset data", rx_data, 8'h00);
      chk("midreset ferr", framing_err, 1'b0);
      chk("midreset ovf", overflow, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(8'h5A, 1'b1);
      send_bit(1'b1);
      @(negedge clk);
      chk("post-reset count", fifo_count, 1);
      pop_chk("post-reset", 8'h5A);
      @(negedge clk);
      chk("post-reset drained", fifo_count, 0);

`ifdef FAB_UART_RX_PARITY_EN
      chk("no parity errors so far", perr_cnt, 0);
      f0 = perr_cnt;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      send_bit(1'b1);
      @(negedge clk);
      chk("parity err pulses", perr_cnt - f0, 1);
      chk("parity err count", fifo_count, 1);
      pop_chk("parity err byte", 8'h07);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fab_uart_rx.md
Name: fab_uart_rx

Overview:
- Fabric-side 8N1 UART receiver with a 16x-oversampling front end and a first-word-fallthrough receive FIFO.
- Consumes the serial stream driven by the MSS MMUART_0_TXD pin, i.e. it is the far end of that link.
- Delivers bytes to fabric logic over a valid/ready interface.
- Runs on the CCC fabric clock; reset comes from the fabric reset tree.

Parameters:
BAUD_DIV, 27, clock cycles per oversample tick (CLK_BASE / (baud × 16)); 27 ≈ 115200 baud at 50 MHz; legal range 1..65535
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries

Ports:
CLK_BASE  input  1  fabric clock; all logic is rising-edge
RESET_N  input  1  asynchronous active-low reset
RXD  input  1  serial input; asynchronous to CLK_BASE; idles high
RX_DATA  output  8  byte at FIFO head; valid only while RX_VALID=1
RX_VALID  output  1  FIFO non-empty
RX_READY  input  1  consumer accepts RX_DATA when RX_VALID & RX_READY
FIFO_COUNT  output  FIFO_AW+1  current FIFO occupancy
FRAMING_ERR  output  1  one-cycle pulse: stop bit sampled low
OVERFLOW  output  1  one-cycle pulse: received byte dropped because FIFO full
PARITY_ERR  output  1  one-cycle pulse: parity mismatch (present only with macro, see Optional Feature)

Behaviour:
- Reset values (asynchronous, RESET_N low):
  - synchronizer flops = 1; FSM = IDLE; tick counter, oversample counter, bit counter, shift register = 0
  - FIFO pointers = 0; RX_VALID = 0; FIFO_COUNT = 0; FRAMING_ERR / OVERFLOW / PARITY_ERR = 0; RX_DATA = 0
- Reset mid-frame aborts the frame and empties the FIFO. After reset release, the next falling edge starts a fresh frame.
- RXD passes through a 2-flop synchronizer to give rxd_s. A third flop, rxd_d, detects falling edges (rxd_d=1, rxd_s=0).
- Tick generator: counts 0..BAUD_DIV-1 and wraps. A tick is asserted for one cycle at the terminal count. It free-runs in all states.
- Oversample counter (os_cnt, 4 bits): advances only on ticks. It is cleared to 0 on start detect and on every bit-boundary transition.
- FSM states and transitions:
  - IDLE: on a falling edge of rxd_s, clear os_cnt and go to START.
  - START: on the tick where os_cnt==7 (mid-bit), if rxd_s==0, clear os_cnt and go to DATA; otherwise go to IDLE (glitch rejected, nothing reported).
  - DATA: on the tick where os_cnt==15, sample rxd_s and shift it in LSB-first. After 8 bits, go to STOP, or to PARITY when the macro is defined.
  - PARITY (macro only): on the tick where os_cnt==15, sample the parity bit and go to STOP.
  - STOP: on the tick where os_cnt==15, sample rxd_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse FRAMING_ERR, discard the byte, go to IDLE.
    - IDLE requires a new falling edge, so a held-low line (break) produces exactly one FRAMING_ERR and nothing further until RXD returns high and falls again.
- FIFO:
  - Storage is 2**FIFO_AW × 8. Pointers are FIFO_AW+1 bits wide and wrap naturally.
  - RX_DATA = mem[rd_ptr] (first-word fallthrough). RX_VALID = (FIFO_COUNT != 0).
  - Pop when RX_VALID & RX_READY. RX_READY while empty has no effect.
  - Push while full and not popping: byte dropped, OVERFLOW pulses for one cycle, contents unchanged.
  - Push and pop in the same cycle: both take effect, including when full (count unchanged, no OVERFLOW) and when empty is impossible because pop requires RX_VALID.
- Latency: the byte is written on the clock edge ending the STOP sampling-tick cycle. RX_VALID is high in the following cycle.
- Error pulses are registered and coincide with that same edge.

Optional Feature:
- Macro: FAB_UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: the PARITY state is present, and the received bit must equal the XOR of the 8 data bits (even parity).
  - On mismatch, PARITY_ERR pulses together with the STOP-sample edge. The byte is still pushed if the stop bit is good.
  - PARITY_ERR port exists.
- Undefined:
  - Frame is 8N1; the PARITY state and PARITY_ERR port are absent.

Test Plan:
- BAUD_DIV=2 (32 clk/bit), send 0xA5 8N1, RX_READY=0 -> FIFO_COUNT=1, RX_VALID=1, RX_DATA=0xA5 one cycle after the stop-sample tick; no error pulses.
- 0 V glitch of 8 clocks on idle RXD -> FSM returns to IDLE; FIFO_COUNT=0; no FRAMING_ERR.
- Send 0x3C with stop bit forced 0, then RXD held low for 5 bit times -> exactly one FRAMING_ERR pulse; FIFO_COUNT=0; then 0x81 is received correctly after RXD returns high.
- FIFO_AW=4, RX_READY=0, send 17 bytes 0x00..0x10 -> FIFO_COUNT=16 and one OVERFLOW on byte 0x10; draining yields 0x00..0x0F in order.
- With the FIFO full, assert RX_READY on the exact push cycle of an incoming byte -> no OVERFLOW; FIFO_COUNT stays 16; the new byte appears last.
- Assert RESET_N low mid-frame with 3 bytes queued -> all outputs at reset values; the next full frame 0x5A is received as the sole entry. With FAB_UART_RX_PARITY_EN, 0x07 with parity bit 0 -> PARITY_ERR pulse and 0x07 still queued.
